// File: rtl/serial_tx_arb_pkg.sv
// Shared types and constants for the serial transmitter arbiter.
package serial_tx_arb_pkg;

    localparam int BYTE_W            = 8;
    localparam int DEF_START_TIMEOUT = 8;
    localparam int MAX_REQ           = 8;
    localparam int IDX_W             = 3;

    typedef enum logic [1:0] {
        ARB_IDLE       = 2'd0,
        ARB_LAUNCH     = 2'd1,
        ARB_WAIT_START = 2'd2,
        ARB_WAIT_DONE  = 2'd3
    } arb_state_e;

    // Index of the set bit of a one-hot vector (0 when no bit is set).
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = {IDX_W{1'b0}};
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/serial_tx_arbiter_rr_picker.sv
// Round-robin picker: first requester in the mask at or after rr_ptr, wrapping.
module rr_picker
    import serial_tx_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req_mask,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic               found
);

    logic [2*NUM_REQ-1:0] dbl_s;
    logic [2*NUM_REQ-1:0] back_s;
    logic [NUM_REQ-1:0]   rot_s;
    logic [NUM_REQ-1:0]   rot_pick_s;

    // Rotate so rr_ptr lands on bit 0, take the lowest set bit, rotate back.
    always_comb begin
        dbl_s      = {req_mask, req_mask} >> rr_ptr;
        rot_s      = dbl_s[NUM_REQ-1:0];
        rot_pick_s = '0;
        found      = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && rot_s[k]) begin
                rot_pick_s[k] = 1'b1;
                found         = 1'b1;
            end else begin
                rot_pick_s[k] = rot_pick_s[k];
            end
        end
        back_s = {rot_pick_s, rot_pick_s} << rr_ptr;
        pick   = back_s[2*NUM_REQ-1:NUM_REQ];
    end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter sharing one serial transmitter among NUM_REQ byte
// producers, with optional packet locking and a start-of-frame watchdog.
module serial_tx_arbiter
    import serial_tx_arb_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = DEF_START_TIMEOUT
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*BYTE_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        grant,
    output logic [BYTE_W-1:0]         tx_data,
    output logic                      tx_data_available,
    input  logic                      tx_ready,
    output logic                      start_error
);

    localparam int                 CNT_W     = 16;
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W-1:0]   IDX_ONE   = IDX_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_LIMIT = CNT_W'(START_TIMEOUT - 1);

    arb_state_e           state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                 lock_q, lock_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [CNT_W-1:0]     start_cnt_q, start_cnt_d;
    logic [BYTE_W-1:0]    tx_data_q, tx_data_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic                 tx_dav_q, tx_dav_d;
    logic                 start_error_q, start_error_d;

    logic [NUM_REQ-1:0]   elig_s;
    logic [NUM_REQ-1:0]   req_mask_s;
    logic [NUM_REQ-1:0]   pick_s;
    logic                 found_s;
    logic [MAX_REQ-1:0]   pick8_s;
    logic [IDX_W-1:0]     pick_idx_s;
    logic [BYTE_W-1:0]    sel_byte_s;
    logic                 sel_last_s;
    logic                 accept_s;
    logic [NUM_REQ-1:0]   req_ready_s;

    // While a packet is open only its owner may compete for the transmitter.
    always_comb begin
        elig_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (lock_q) begin
                elig_s[i] = (owner_q == IDX_W'(i));
            end else begin
                elig_s[i] = 1'b1;
            end
        end
        req_mask_s = req_valid & elig_s;
    end

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_mask (req_mask_s),
        .rr_ptr   (rr_ptr_q),
        .pick     (pick_s),
        .found    (found_s)
    );

    // Mux out the picked requester's byte, last flag and index.
    always_comb begin
        sel_byte_s = '0;
        pick8_s    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_byte_s = sel_byte_s | (req_data[i*BYTE_W +: BYTE_W] & {BYTE_W{pick_s[i]}});
        end
        pick8_s[NUM_REQ-1:0] = pick_s;
        pick_idx_s           = onehot_to_idx(pick8_s);
        sel_last_s           = |(req_last & pick_s);
    end

    // Accept only from IDLE with an idle transmitter; masked during reset so
    // req_ready is 0 while reset_n is low.
    assign accept_s = reset_n & (state_q == ARB_IDLE) & tx_ready & found_s;

    // Next-state, lock/pointer bookkeeping and output register updates.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        lock_d        = lock_q;
        owner_d       = owner_q;
        start_cnt_d   = start_cnt_q;
        tx_data_d     = tx_data_q;
        grant_d       = grant_q;
        tx_dav_d      = 1'b0;
        start_error_d = start_error_q;
        req_ready_s   = '0;
        case (state_q)
            ARB_IDLE: begin
                if (accept_s) begin
                    req_ready_s = pick_s;
                    tx_data_d   = sel_byte_s;
                    grant_d     = pick_s;
                    tx_dav_d    = 1'b1;
                    state_d     = ARB_LAUNCH;
                    if (sel_last_s) begin
                        // Packet ends: release the lock and rotate past the owner.
                        lock_d = 1'b0;
                        if (pick_idx_s == LAST_IDX) begin
                            rr_ptr_d = '0;
                        end else begin
                            rr_ptr_d = pick_idx_s + IDX_ONE;
                        end
                    end else begin
                        lock_d  = 1'b1;
                        owner_d = pick_idx_s;
                    end
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_LAUNCH: begin
                start_cnt_d = '0;
                state_d     = ARB_WAIT_START;
            end
            ARB_WAIT_START: begin
                if (!tx_ready) begin
                    state_d = ARB_WAIT_DONE;
                end else if ((start_cnt_q + CNT_ONE) == CNT_LIMIT) begin
                    // Transmitter never went busy: drop the byte and the packet.
                    start_error_d = 1'b1;
                    lock_d        = 1'b0;
                    grant_d       = '0;
                    state_d       = ARB_IDLE;
                end else begin
                    start_cnt_d = start_cnt_q + CNT_ONE;
                end
            end
            ARB_WAIT_DONE: begin
                if (tx_ready) begin
                    state_d = ARB_IDLE;
                    if (lock_q) begin
                        grant_d = grant_q;
                    end else begin
                        grant_d = '0;
                    end
                end else begin
                    state_d = ARB_WAIT_DONE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ARB_IDLE;
            rr_ptr_q      <= '0;
            lock_q        <= 1'b0;
            owner_q       <= '0;
            start_cnt_q   <= '0;
            tx_data_q     <= '0;
            grant_q       <= '0;
            tx_dav_q      <= 1'b0;
            start_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            lock_q        <= lock_d;
            owner_q       <= owner_d;
            start_cnt_q   <= start_cnt_d;
            tx_data_q     <= tx_data_d;
            grant_q       <= grant_d;
            tx_dav_q      <= tx_dav_d;
            start_error_q <= start_error_d;
        end
    end

    assign req_ready         = req_ready_s;
    assign grant             = grant_q;
    assign tx_data           = tx_data_q;
    assign tx_data_available = tx_dav_q;
    assign start_error       = start_error_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Self-checking bench for serial_tx_arbiter: behavioural transmitter,
// queue-driven requesters and a transaction-level reference model.
module tb_serial_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 8;

    logic             clock = 1'b0;
    logic             reset_n;
    logic [N-1:0]     req_valid;
    logic [N*8-1:0]   req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ready;
    logic [N-1:0]     grant;
    logic [7:0]       tx_data;
    logic             tx_data_available;
    logic             tx_ready;
    logic             start_error;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    serial_tx_arbiter #(.NUM_REQ(N), .START_TIMEOUT(TO)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .req_valid         (req_valid),
        .req_data          (req_data),
        .req_last          (req_last),
        .req_ready         (req_ready),
        .grant             (grant),
        .tx_data           (tx_data),
        .tx_data_available (tx_data_available),
        .tx_ready          (tx_ready),
        .start_error       (start_error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- requesters: per-requester byte queues ----------------
    logic [8:0]   rq [N][$];     // {last, data}, written by the test only
    int           rq_head [N];   // consumed entries, written by the driver only
    logic [N-1:0] ready_seen;    // req_ready sampled mid-cycle

    initial for (int i = 0; i < N; i++) rq_head[i] = 0;

    // ---------------- transmitter: 0 normal, 1 never starts, 2 held busy ---
    int   tx_mode   = 0;
    int   frame_len = 10;
    int   tx_busy   = 0;
    logic tx_next   = 1'b1;
    logic [7:0] sent [$];
    int   dav_cyc   = 0;

    always @(negedge clock) begin
        if (tx_data_available === 1'b1) begin
            sent.push_back(tx_data);
            dav_cyc = cyc;
            if (tx_mode == 0) tx_busy = frame_len;
        end else if (tx_busy > 0) begin
            tx_busy = tx_busy - 1;
        end
        if (tx_mode != 0) tx_busy = 0;
        tx_next = (tx_mode == 2) ? 1'b0 : (tx_mode == 1) ? 1'b1 : (tx_busy == 0);
    end

    // Inputs change just after the active edge.
    always @(posedge clock) begin
        #1;
        tx_ready = tx_next;
        for (int i = 0; i < N; i++) begin
            if (ready_seen[i] && rq[i].size() > rq_head[i]) rq_head[i] = rq_head[i] + 1;
            if (rq[i].size() > rq_head[i]) begin
                req_valid[i]       = 1'b1;
                req_data[i*8 +: 8] = rq[i][rq_head[i]][7:0];
                req_last[i]        = rq[i][rq_head[i]][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
        end
    endtask

    // ---------------- reference model (frame-level view) ----------------
    bit         m_active, m_started, m_lock, m_dav, m_err;
    int         m_age, m_ptr, m_owner;
    logic [N-1:0] m_grant;
    logic [7:0] m_txdata;

    task automatic compare_loop();
        forever begin
            @(negedge clock);
            if (reset_n !== 1'b1) begin
                m_active = 0; m_started = 0; m_lock = 0; m_dav = 0; m_err = 0;
                m_age = 0; m_ptr = 0; m_owner = 0; m_grant = '0; m_txdata = 8'h00;
                ready_seen = '0;
            end else begin
                int           sel;
                bit           acc;
                logic [N-1:0] exp_rdy;
                acc = 0; sel = 0; exp_rdy = '0;
                if (!m_active && tx_ready === 1'b1) begin
                    for (int k = 0; k < N; k++) begin
                        int i;
                        i = (m_ptr + k) % N;
                        if (!acc && req_valid[i] && (!m_lock || m_owner == i)) begin
                            acc = 1; sel = i;
                        end
                    end
                end
                if (acc) exp_rdy[sel] = 1'b1;
                chk("req_ready", 32'(req_ready), 32'(exp_rdy));
                chk("grant", 32'(grant), 32'(m_grant));
                chk("tx_data", 32'(tx_data), 32'(m_txdata));
                chk("tx_data_available", 32'(tx_data_available), 32'(m_dav));
                chk("start_error", 32'(start_error), 32'(m_err));
                ready_seen = req_ready;
                // advance to the values expected after the next edge
                m_dav = 0;
                if (acc) begin
                    m_active = 1; m_age = 0; m_started = 0; m_dav = 1;
                    m_txdata = req_data[sel*8 +: 8];
                    m_grant  = '0; m_grant[sel] = 1'b1;
                    if (req_last[sel]) begin
                        m_lock = 0; m_ptr = (sel + 1) % N;
                    end else begin
                        m_lock = 1; m_owner = sel;
                    end
                end else if (m_active) begin
                    if (m_age == 0) begin
                        m_age = 1;
                    end else if (!m_started) begin
                        if (tx_ready === 1'b0) begin
                            m_started = 1;
                        end else if (m_age == TO - 1) begin
                            m_err = 1; m_lock = 0; m_grant = '0; m_active = 0;
                        end
                        m_age = m_age + 1;
                    end else if (tx_ready === 1'b1) begin
                        m_active = 0;
                        if (!m_lock) m_grant = '0;
                    end
                end
            end
        end
    endtask

    function automatic bit pending();
        bit p;
        p = 0;
        for (int i = 0; i < N; i++) if (rq[i].size() > rq_head[i]) p = 1;
        return p;
    endfunction

    task automatic push(input int r, input bit last, input logic [7:0] b);
        rq[r].push_back({last, b});
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (k < budget && pending()) begin @(negedge clock); k++; end
        repeat (3) @(negedge clock);
        while (k < budget && tx_ready !== 1'b1) begin @(negedge clock); k++; end
        repeat (2) @(negedge clock);
        chk("drain_budget", 32'(k < budget), 32'd1);
    endtask

    initial begin
        int base, cnt, cd, ce, k;
        reset_n = 1'b0; tx_ready = 1'b1;
        req_valid = '0; req_data = '0; req_last = '0; ready_seen = '0;
        fork compare_loop(); join_none
        repeat (3) @(negedge clock);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_dav", 32'(tx_data_available), 32'd0);
        chk("rst_error", 32'(start_error), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        #2 reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // fairness: three simultaneous single-byte packets, r0 queues a second
        base = sent.size(); frame_len = 12;
        push(0, 1, 8'h11); push(0, 1, 8'h44); push(1, 1, 8'h22); push(2, 1, 8'h33);
        drain(800);
        chk("fair_n", 32'(sent.size() - base), 32'd4);
        chk("fair_0", 32'(sent[base]), 32'h11);
        chk("fair_1", 32'(sent[base+1]), 32'h22);
        chk("fair_2", 32'(sent[base+2]), 32'h33);
        chk("fair_3", 32'(sent[base+3]), 32'h44);

        // single byte
        base = sent.size(); frame_len = 20;
        push(0, 1, 8'hAB);
        drain(400);
        chk("single_n", 32'(sent.size() - base), 32'd1);
        chk("single_b", 32'(sent[base]), 32'hAB);

        // packet lock with the owner idling between bytes
        base = sent.size(); frame_len = 10;
        push(1, 0, 8'hA0); push(2, 1, 8'h55);
        repeat (40) @(negedge clock);
        chk("lock_gap_grant", 32'(grant), 32'b0010);
        chk("lock_gap_n", 32'(sent.size() - base), 32'd1);
        push(1, 0, 8'hA1); push(1, 1, 8'hA2);
        drain(800);
        chk("lock_0", 32'(sent[base]), 32'hA0);
        chk("lock_1", 32'(sent[base+1]), 32'hA1);
        chk("lock_2", 32'(sent[base+2]), 32'hA2);
        chk("lock_3", 32'(sent[base+3]), 32'h55);

        // backpressure: transmitter busy for 100 cycles
        tx_mode = 2;
        repeat (2) @(negedge clock);
        push(0, 1, 8'hC3);
        cnt = 0;
        repeat (100) begin @(negedge clock); if (req_ready !== '0) cnt++; end
        chk("bp_no_ready", 32'(cnt), 32'd0);
        tx_mode = 0;
        k = 0;
        while (k < 10 && tx_ready !== 1'b1) begin @(negedge clock); k++; end
        chk("bp_accept", 32'(req_ready), 32'b0001);
        drain(400);

        // start timeout: transmitter never drops tx_ready
        base = sent.size(); tx_mode = 1;
        push(3, 1, 8'h5A);
        k = 0;
        while (k < 20 && tx_data_available !== 1'b1) begin @(negedge clock); k++; end
        cd = cyc;
        while (k < 60 && start_error !== 1'b1) begin @(negedge clock); k++; end
        ce = cyc;
        chk("to_delay", 32'(ce - cd), 32'(TO));
        chk("to_grant", 32'(grant), 32'd0);
        chk("to_byte", 32'(sent[base]), 32'h5A);
        tx_mode = 0;
        push(1, 1, 8'h66);
        drain(400);
        chk("to_next_n", 32'(sent.size() - base), 32'd2);
        chk("to_next_b", 32'(sent[base+1]), 32'h66);

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            int r;
            @(negedge clock);
            r = $urandom_range(0, 99);
            if (r < 3) tx_mode = 2; else if (r < 4) tx_mode = 1; else if (r < 20) tx_mode = 0;
            frame_len = $urandom_range(1, 12);
            if ($urandom_range(0, 3) == 0) begin
                int q;
                q = $urandom_range(0, N - 1);
                if (rq[q].size() - rq_head[q] < 3)
                    push(q, ($urandom_range(0, 2) != 0), 8'($urandom_range(0, 255)));
            end
        end
        tx_mode = 0; frame_len = 6;
        for (int i = 0; i < N; i++) push(i, 1, 8'(8'hE0 + i));
        drain(4000);

        // reset during a frame
        base = sent.size(); frame_len = 400;
        push(2, 1, 8'h99);
        k = 0;
        while (k < 40 && tx_data_available !== 1'b1) begin @(negedge clock); k++; end
        repeat (10) @(negedge clock);
        push(3, 1, 8'h77);
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b0; tx_mode = 2;
        #1;
        chk("mid_grant", 32'(grant), 32'd0);
        chk("mid_tx_data", 32'(tx_data), 32'd0);
        chk("mid_dav", 32'(tx_data_available), 32'd0);
        chk("mid_error", 32'(start_error), 32'd0);
        chk("mid_ready", 32'(req_ready), 32'd0);
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b1;
        cnt = 0;
        repeat (30) begin @(negedge clock); if (req_ready !== '0) cnt++; end
        chk("mid_hold", 32'(cnt), 32'd0);
        tx_mode = 0; frame_len = 10;
        k = 0;
        while (k < 20 && sent.size() - base < 2) begin @(negedge clock); k++; end
        chk("mid_n", 32'(sent.size() - base), 32'd2);
        chk("mid_77", 32'(sent[base+1]), 32'h77);
        drain(400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
